eth_axis_pkt_fifo: RTL and testbench

//  Parametrised AXI-Stream packet FIFO on the flat AXIS TX/RX boundary of the Ethernet top-level.

---
 rtl/eth_top_pkg.sv | 16 +
 rtl/eth_pkt_fifo_ram.sv | 26 ++
 rtl/eth_axis_pkt_fifo.sv | 178 +++++++++++++++++
 tb/tb_eth_axis_pkt_fifo.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_top_pkg.sv
// Shared Ethernet top-level types: flat AXI-Stream field types and the packet FIFO write-state encoding.
package eth_top_pkg;

    localparam int unsigned AxisDataWidth = 8;
    localparam int unsigned AxisKeepWidth = (AxisDataWidth / 8 < 1) ? 1 : AxisDataWidth / 8;

    typedef logic [AxisDataWidth-1:0] axis_tdata_t;
    typedef logic [AxisKeepWidth-1:0] axis_tkeep_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DROP
    } pkt_fifo_state_e;

endpackage

// File: rtl/eth_pkt_fifo_ram.sv
// Simple dual-port packet buffer: one write port, one read port with registered read data.
module eth_pkt_fifo_ram #(
    parameter int unsigned Width = 11,
    parameter int unsigned Depth = 2048,
    localparam int unsigned AW   = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/eth_axis_pkt_fifo.sv
// AXI-Stream packet FIFO between SoC and MAC streams: store-and-forward with error/overflow
// frame dropping, or cut-through with backpressure; exports fill level and drop statistics.
module eth_axis_pkt_fifo
    import eth_top_pkg::*;
#(
    parameter int unsigned DataWidth    = 8,
    parameter int unsigned Depth        = 2048,
    parameter bit          StoreForward = 1'b1,
    parameter bit          DropOnError  = 1'b1,
    parameter int unsigned CntWidth     = 16,
    localparam int unsigned KeepWidth   = (DataWidth / 8 < 1) ? 1 : DataWidth / 8,
    localparam int unsigned AW          = $clog2(Depth),
    localparam int unsigned PW          = AW + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] s_axis_tdata_i,
    input  logic [KeepWidth-1:0] s_axis_tkeep_i,
    input  logic                 s_axis_tlast_i,
    input  logic                 s_axis_tuser_i,
    input  logic                 s_axis_tvalid_i,
    output logic                 s_axis_tready_o,
    output logic [DataWidth-1:0] m_axis_tdata_o,
    output logic [KeepWidth-1:0] m_axis_tkeep_o,
    output logic                 m_axis_tlast_o,
    output logic                 m_axis_tuser_o,
    output logic                 m_axis_tvalid_o,
    input  logic                 m_axis_tready_i,
    input  logic                 cnt_clear_i,
    output logic [PW-1:0]        fill_level_o,
    output logic [CntWidth-1:0]  drop_cnt_o,
    output logic [CntWidth-1:0]  ovf_cnt_o
);

    localparam int unsigned MemW = DataWidth + KeepWidth + 2;

    pkt_fifo_state_e     state_q, state_d;
    logic [PW-1:0]       wr_q, wr_d, commit_q, commit_d, rd_q, rd_d, pf_q, pf_d, fill_q;
    logic                rdy_q;
    logic                v1_q, v1_d, out_v_q, out_v_d;
    logic [MemW-1:0]     out_q, out_d, wdata, rdata;
    logic [CntWidth-1:0] drop_q, drop_d, ovf_q, ovf_d;
    logic                full, hs, we, re, load, pop, drop_inc, ovf_inc;

    assign full            = (wr_q - rd_q) == PW'(Depth);
    assign s_axis_tready_o = rdy_q & (StoreForward | ~full);
    assign hs              = s_axis_tvalid_i & s_axis_tready_o;
    assign wdata           = {s_axis_tlast_i, s_axis_tuser_i, s_axis_tkeep_i, s_axis_tdata_i};

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        commit_d = commit_q;
        we       = 1'b0;
        drop_inc = 1'b0;
        ovf_inc  = 1'b0;
        if (hs) begin
            if (!StoreForward) begin
                we       = 1'b1;
                wr_d     = wr_q + PW'(1);
                commit_d = wr_q + PW'(1);
            end else begin
                unique case (state_q)
                    IDLE, ACTIVE: begin
                        if (full) begin
                            // single-beat overflow closes immediately, otherwise swallow the rest
                            if (s_axis_tlast_i) begin
                                wr_d    = commit_q;
                                ovf_inc = 1'b1;
                                state_d = IDLE;
                            end else begin
                                state_d = DROP;
                            end
                        end else if (s_axis_tlast_i && s_axis_tuser_i && DropOnError) begin
                            wr_d     = commit_q;
                            drop_inc = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            we   = 1'b1;
                            wr_d = wr_q + PW'(1);
                            if (s_axis_tlast_i) begin
                                commit_d = wr_q + PW'(1);
                                state_d  = IDLE;
                            end else begin
                                state_d = ACTIVE;
                            end
                        end
                    end
                    DROP: begin
                        if (s_axis_tlast_i) begin
                            wr_d    = commit_q;
                            ovf_inc = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // pf_q prefetches into the RAM/output registers; rd_q frees space only on egress handshake
    always_comb begin
        load    = v1_q & (~out_v_q | m_axis_tready_i);
        re      = (pf_q != commit_q) & (~v1_q | load);
        pop     = out_v_q & m_axis_tready_i;
        pf_d    = pf_q + {{AW{1'b0}}, re};
        rd_d    = rd_q + {{AW{1'b0}}, pop};
        v1_d    = re | (v1_q & ~load);
        out_v_d = load | (out_v_q & ~m_axis_tready_i);
        out_d   = load ? rdata : out_q;
    end

    always_comb begin
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (cnt_clear_i) begin
            drop_d = '0;
            ovf_d  = '0;
        end else begin
            if (drop_inc && (drop_q != '1)) drop_d = drop_q + CntWidth'(1);
            if (ovf_inc && (ovf_q != '1)) ovf_d = ovf_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            wr_q     <= '0;
            commit_q <= '0;
            rd_q     <= '0;
            pf_q     <= '0;
            fill_q   <= '0;
            rdy_q    <= 1'b0;
            v1_q     <= 1'b0;
            out_v_q  <= 1'b0;
            out_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            commit_q <= commit_d;
            rd_q     <= rd_d;
            pf_q     <= pf_d;
            fill_q   <= wr_d - rd_d;
            rdy_q    <= 1'b1;
            v1_q     <= v1_d;
            out_v_q  <= out_v_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    eth_pkt_fifo_ram #(
        .Width(MemW),
        .Depth(Depth)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (we),
        .waddr_i(wr_q[AW-1:0]),
        .wdata_i(wdata),
        .re_i   (re),
        .raddr_i(pf_q[AW-1:0]),
        .rdata_o(rdata)
    );

    assign m_axis_tdata_o  = out_q[DataWidth-1:0];
    assign m_axis_tkeep_o  = out_q[DataWidth +: KeepWidth];
    assign m_axis_tuser_o  = out_q[MemW-2];
    assign m_axis_tlast_o  = out_q[MemW-1];
    assign m_axis_tvalid_o = out_v_q;
    assign fill_level_o    = fill_q;
    assign drop_cnt_o      = drop_q;
    assign ovf_cnt_o       = ovf_q;

endmodule

// File: tb/tb_eth_axis_pkt_fifo.sv
// Scoreboard bench for eth_axis_pkt_fifo: SF Depth 2048, SF Depth 16 and CT Depth 16 instances
// share one ingress driver; sel picks which instance is driven and monitored.
module tb_eth_axis_pkt_fifo;

    localparam int unsigned DW = 8;
    localparam int unsigned KW = 1;
    localparam int unsigned CW = 2;
    localparam int unsigned BW = DW + KW + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast, s_tuser, s_tvalid, m_tready, cnt_clear;
    int unsigned   sel;

    logic          s_tready  [3];
    logic [DW-1:0] m_tdata   [3];
    logic [KW-1:0] m_tkeep   [3];
    logic          m_tlast   [3];
    logic          m_tuser   [3];
    logic          m_tvalid  [3];
    logic [11:0]   fill      [3];
    logic [CW-1:0] drop_cnt  [3];
    logic [CW-1:0] ovf_cnt   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned D  = (g == 0) ? 2048 : 16;
        localparam bit          SF = (g != 2);
        logic [$clog2(D):0] fl;
        eth_axis_pkt_fifo #(
            .DataWidth(DW),
            .Depth(D),
            .StoreForward(SF),
            .DropOnError(1'b1),
            .CntWidth(CW)
        ) u_dut (
            .clk_i          (clk),
            .rst_ni         (rst_n),
            .s_axis_tdata_i (s_tdata),
            .s_axis_tkeep_i (s_tkeep),
            .s_axis_tlast_i (s_tlast),
            .s_axis_tuser_i (s_tuser),
            .s_axis_tvalid_i(s_tvalid && (sel == g)),
            .s_axis_tready_o(s_tready[g]),
            .m_axis_tdata_o (m_tdata[g]),
            .m_axis_tkeep_o (m_tkeep[g]),
            .m_axis_tlast_o (m_tlast[g]),
            .m_axis_tuser_o (m_tuser[g]),
            .m_axis_tvalid_o(m_tvalid[g]),
            .m_axis_tready_i(m_tready),
            .cnt_clear_i    (cnt_clear),
            .fill_level_o   (fl),
            .drop_cnt_o     (drop_cnt[g]),
            .ovf_cnt_o      (ovf_cnt[g])
        );
        assign fill[g] = 12'(fl);
    end

    int unsigned   n_chk = 0;
    int unsigned   n_bad = 0;
    int unsigned   n_out = 0;
    logic [BW-1:0] exp_q [$];
    logic [BW-1:0] prev_beat;
    bit            stall_prev = 1'b0;
    bit            t1_watch = 1'b0;
    bit            early = 1'b0;
    bit            bp_run;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [BW-1:0] beat;
        beat = {m_tlast[sel], m_tuser[sel], m_tkeep[sel], m_tdata[sel]};
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(m_tvalid[sel]), 32'd1);
                chk("hold_data", 32'(beat), 32'(prev_beat));
            end
            if (m_tvalid[sel] && m_tready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", 32'(beat), 32'hFFFF_FFFF);
                else chk("beat", 32'(beat), 32'(exp_q.pop_front()));
                n_out++;
            end
            stall_prev = m_tvalid[sel] && !m_tready;
            prev_beat  = beat;
        end
        if (t1_watch && m_tvalid[0]) early = 1'b1;
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                             input logic u, input bit push);
        int unsigned n  = 0;
        bit          ok = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_tready[sel]) break;
            n++;
            if (n > 5000) begin
                chk("s_tready_timeout", 32'd0, 32'd1);
                ok = 1'b0;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            if (push) exp_q.push_back({l, u, k, d});
        end
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int unsigned len, input logic user, input bit push);
        for (int unsigned i = 0; i < len; i++)
            send_beat(DW'($urandom), KW'($urandom), i == len - 1, (i == len - 1) ? user : 1'b0, push);
    endtask

    task automatic wait_drain(input string tag);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 50000) begin
            tick(1);
            n++;
        end
        chk(tag, exp_q.size(), 0);
        tick(4);
    endtask

    initial begin
        int unsigned base, len, n;
        s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = 1'b0; s_tvalid = 1'b0;
        m_tready = 1'b1; cnt_clear = 1'b0; sel = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 32'(s_tready[0]), 0);
        chk("rst_m_tvalid", 32'(m_tvalid[0]), 0);
        chk("rst_m_tdata", 32'(m_tdata[0]), 0);
        chk("rst_fill", 32'(fill[0]), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1);
        @(negedge clk);
        chk("post_rst_s_tready", 32'(s_tready[0]), 1);
        tick(1);

        // SF 64-beat frame: nothing before tlast, first beat exactly 2 cycles after commit
        base = n_out;
        t1_watch = 1'b1;
        send_frame(64, 1'b0, 1'b1);
        t1_watch = 1'b0;
        chk("sf_early_valid", 32'(early), 0);
        @(negedge clk); chk("sf_lat_c0", 32'(m_tvalid[0]), 0);
        @(negedge clk); chk("sf_lat_c1", 32'(m_tvalid[0]), 0);
        @(negedge clk); chk("sf_lat_c2", 32'(m_tvalid[0]), 1);
        tick(1);
        wait_drain("sf64_drain");
        chk("sf64_count", n_out - base, 64);
        chk("sf64_fill", 32'(fill[0]), 0);

        // Depth 16 SF: oversized frame dropped, following frame intact, counter saturates/clears
        sel = 1;
        send_frame(24, 1'b0, 1'b0);
        tick(2);
        chk("ovf_cnt_1", 32'(ovf_cnt[1]), 1);
        chk("ovf_fill", 32'(fill[1]), 0);
        base = n_out;
        send_frame(8, 1'b0, 1'b1);
        wait_drain("ovf_next_drain");
        chk("ovf_next_count", n_out - base, 8);
        for (int i = 0; i < 3; i++) send_frame(24, 1'b0, 1'b0);
        tick(2);
        chk("ovf_cnt_sat", 32'(ovf_cnt[1]), 3);
        cnt_clear = 1'b1;
        tick(1);
        cnt_clear = 1'b0;
        chk("ovf_cnt_clear", 32'(ovf_cnt[1]), 0);

        // SF errored frame: discarded, counted, fill returns to 0
        sel = 0;
        base = n_out;
        send_frame(20, 1'b1, 1'b0);
        tick(8);
        chk("err_drop_cnt", 32'(drop_cnt[0]), 1);
        chk("err_fill", 32'(fill[0]), 0);
        chk("err_no_output", n_out - base, 0);

        // CT Depth 16: backpressure after 16 beats, then all 20 in order (tuser passed through)
        sel = 2;
        m_tready = 1'b0;
        base = n_out;
        for (int unsigned i = 0; i < 16; i++) send_beat(DW'(i * 7 + 3), 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("ct_s_tready_full", 32'(s_tready[2]), 0);
        chk("ct_fill_16", 32'(fill[2]), 16);
        tick(1);
        m_tready = 1'b1;
        for (int unsigned i = 16; i < 20; i++)
            send_beat(DW'(i * 7 + 3), 1'b1, i == 19, i == 19, 1'b1);
        wait_drain("ct_drain");
        chk("ct_count", n_out - base, 20);

        // Random egress backpressure over 100 frames
        sel = 0;
        base = n_out;
        n = 0;
        bp_run = 1'b1;
        fork
            begin
                for (int f = 0; f < 100; f++) begin
                    len = (f == 0) ? 1522 : (f == 1) ? 1 :
                          (f % 10 == 5) ? $urandom_range(1, 1522) : $urandom_range(1, 64);
                    n += len;
                    for (int w = 0; w < 20000 && (32'(fill[0]) + len > 2048); w++) tick(1);
                    send_frame(len, 1'b0, 1'b1);
                end
                wait_drain("rand_drain");
                bp_run = 1'b0;
            end
            begin
                while (bp_run) begin
                    tick(1);
                    m_tready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_tready = 1'b1;
        chk("rand_count", n_out - base, n);

        // Reset mid-frame with 5 beats stored
        m_tready = 1'b1;
        send_frame(5, 1'b0, 1'b0);
        s_tlast = 1'b0;
        @(negedge clk);
        chk("pre_rst_fill", 32'(fill[0]), 5);
        tick(1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_fill", 32'(fill[0]), 0);
        chk("mid_rst_valid", 32'(m_tvalid[0]), 0);
        chk("mid_rst_s_tready", 32'(s_tready[0]), 0);
        chk("mid_rst_drop_cnt", 32'(drop_cnt[0]), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        base = n_out;
        send_frame(10, 1'b0, 1'b1);
        wait_drain("post_rst_drain");
        chk("post_rst_count", n_out - base, 10);
        chk("post_rst_fill", 32'(fill[0]), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
